logic_reduce_unit: RTL and testbench

Parametrised, registered successor to the two-input AND primitive: folds a frame of W-bit operands, delivered one per beat over a valid/ready stream, into a single W-bit bitwise AND, OR, XOR or XNOR result. It sits between operand producers and any datapath stage that needs a multi-operand gate result. It replaces ad-hoc trees of fixed 2-input gates wherever operand count or width varies.

---
 rtl/logic_reduce_pkg.sv | 15 +
 rtl/logic_reduce_alu.sv | 24 ++
 rtl/logic_reduce_unit.sv | 140 ++++++++++++++
 tb/tb_logic_reduce_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_reduce_pkg.sv
// Shared encodings for the logic reduction unit: operation codes and FSM states.
package logic_reduce_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/logic_reduce_alu.sv
// Combinational fold step: combines the running accumulator with one operand.
// XNOR folds as XOR; the final inversion is applied when the result is captured.
module logic_reduce_alu
  import logic_reduce_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] operand_i,
  input  logic [1:0]   op_i,
  output logic [W-1:0] fold_o
);

  // Select the bitwise gate for this fold step
  always_comb begin
    fold_o = acc_i ^ operand_i;
    case (op_i)
      OP_AND:  fold_o = acc_i & operand_i;
      OP_OR:   fold_o = acc_i | operand_i;
      default: fold_o = acc_i ^ operand_i;
    endcase
  end

endmodule

// File: rtl/logic_reduce_unit.sv
// Multi-operand AND/OR/XOR/XNOR reduction over a valid/ready beat stream.
// Optional feature macro: LOGIC_REDUCE_PARITY_EN adds out_parity (XOR of out_data bits).
module logic_reduce_unit
  import logic_reduce_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_BEATS = 16,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    op,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_count,
`ifdef LOGIC_REDUCE_PARITY_EN
  output logic          out_parity,
`endif
  output logic          out_ovf
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  state_e        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [W-1:0]  fold;
  logic [CW-1:0] cnt_inc;
  logic [W-1:0]  res_raw;
  logic [1:0]    res_op;
  logic [W-1:0]  res;
  logic          load_out;

  logic_reduce_alu #(.W(W)) u_alu (
    .acc_i     (acc_q),
    .operand_i (in_data),
    .op_i      (op_q),
    .fold_o    (fold)
  );

  assign cnt_inc = cnt_q + CW'(1);
  // XNOR is folded as XOR, so invert once as the result is captured
  assign res     = (res_op == OP_XNOR) ? ~res_raw : res_raw;

  // Next-state and datapath update; in_ready/out_valid depend on state only
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    res_raw    = fold;
    res_op     = op_q;
    load_out   = 1'b0;
    in_ready   = (state_q != ST_HOLD);
    out_valid  = (state_q == ST_HOLD);
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d   = in_data;
          op_d    = op;
          cnt_d   = CW'(1);
          ovf_d   = 1'b0;
          res_raw = in_data;
          res_op  = op;
          if (in_last) begin
            state_d  = ST_HOLD;
            load_out = 1'b1;
          end else begin
            state_d  = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d = fold;
          cnt_d = cnt_inc;
          // Close on in_last, or force-close when the beat budget is used up
          if (in_last || (cnt_inc == MAX_CNT)) begin
            state_d  = ST_HOLD;
            ovf_d    = ~in_last;
            load_out = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_data_d = load_out ? res : out_data_q;
  end

  // State and datapath registers; reset discards any partial frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      op_q       <= OP_AND;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

`ifdef LOGIC_REDUCE_PARITY_EN
  logic par_q;

  // Parity captured together with out_data on HOLD entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           par_q <= 1'b0;
    else if (load_out) par_q <= ^res;
  end

  assign out_parity = par_q;
`endif

endmodule

// File: tb/tb_logic_reduce_unit.sv
module tb_logic_reduce_unit;
  import logic_reduce_pkg::*;

  localparam int W  = 8;
  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    op;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_ovf;
`ifdef LOGIC_REDUCE_PARITY_EN
  logic          out_parity;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic_reduce_unit #(.W(W), .MAX_BEATS(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
`ifdef LOGIC_REDUCE_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ovf   (out_ovf)
  );

`define CHK(TAG, OBS, EXP) \
  begin \
    checks++; \
    assert ((OBS) === (EXP)) else begin \
      failures++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); \
    end \
  end

  task automatic chk_reset(input string tag);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_count !== '0 || out_ovf !== 1'b0) begin
      failures++;
      $error("FAIL %s reset state: valid=%0b data=%0h count=%0d ovf=%0b",
             tag, out_valid, out_data, out_count, out_ovf);
    end
  endtask

  task automatic wait_out_valid(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $error("FAIL %s wait for out_valid expired after %0d cycles", tag, max_cycles);
    end
  endtask

  task automatic beat(input logic [1:0] o, input logic [7:0] d, input logic l);
    op       = o;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    op       = 2'b00;
    in_data  = 8'hxx;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    failures++;
    $error("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b1; op = 2'b00; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_reset("rst");
    `CHK("rst_valid", out_valid, 1'b0)
    `CHK("rst_data",  out_data, 8'h00)
    `CHK("rst_count", out_count, 3'd0)
    `CHK("rst_ovf",   out_ovf, 1'b0)
    rst = 1'b0;
    @(posedge clk); #1;
    `CHK("rst_ready", in_ready, 1'b1)

    beat(OP_AND, 8'hFF, 1'b0);
    `CHK("and_mid_valid", out_valid, 1'b0)
    beat(OP_AND, 8'hF0, 1'b0);
    beat(OP_AND, 8'h3C, 1'b1);
    wait_out_valid("and", 1);
    `CHK("and_valid", out_valid, 1'b1)
    `CHK("and_data",  out_data, 8'h30)
    `CHK("and_count", out_count, 3'd3)
    `CHK("and_ovf",   out_ovf, 1'b0)
    `CHK("and_ready", in_ready, 1'b0)
`ifdef LOGIC_REDUCE_PARITY_EN
    `CHK("and_par", out_parity, 1'b0)
`endif
    drain();
    `CHK("and_drain_valid", out_valid, 1'b0)
    `CHK("and_drain_ready", in_ready, 1'b1)

    beat(OP_XNOR, 8'hA5, 1'b1);
    wait_out_valid("xnor1", 1);
    `CHK("xnor1_data",  out_data, 8'h5A)
    `CHK("xnor1_count", out_count, 3'd1)
    drain();

    beat(OP_XOR, 8'h3C, 1'b1);
    wait_out_valid("xor1", 1);
    `CHK("xor1_data", out_data, 8'h3C)
    drain();

    beat(OP_XOR, 8'h01, 1'b0);
    beat(OP_XOR, 8'h02, 1'b0);
    beat(OP_XOR, 8'h04, 1'b0);
    beat(OP_XOR, 8'h08, 1'b0);
    `CHK("ovf_valid", out_valid, 1'b1)
    `CHK("ovf_data",  out_data, 8'h0F)
    `CHK("ovf_count", out_count, 3'd4)
    `CHK("ovf_flag",  out_ovf, 1'b1)
    `CHK("ovf_ready", in_ready, 1'b0)
    drain();
    `CHK("ovf_clear", out_ovf, 1'b0)
    beat(OP_XOR, 8'h10, 1'b1);
    wait_out_valid("beat5", 1);
    `CHK("beat5_data",  out_data, 8'h10)
    `CHK("beat5_count", out_count, 3'd1)
    `CHK("beat5_ovf",   out_ovf, 1'b0)
    drain();

    beat(OP_AND, 8'hFF, 1'b0);
    beat(OP_AND, 8'hFE, 1'b0);
    beat(OP_AND, 8'hEF, 1'b0);
    beat(OP_AND, 8'h0F, 1'b1);
    wait_out_valid("lastmax", 1);
    `CHK("lastmax_data",  out_data, 8'h0E)
    `CHK("lastmax_count", out_count, 3'd4)
    `CHK("lastmax_ovf",   out_ovf, 1'b0)
    drain();

    beat(OP_AND, 8'hF0, 1'b0);
    beat(OP_OR,  8'h3C, 1'b1);
    wait_out_valid("opchg", 1);
    `CHK("opchg_data", out_data, 8'h30)
    drain();

    beat(OP_OR, 8'h01, 1'b0);
    beat(OP_OR, 8'h80, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
      `CHK("bp_valid", out_valid, 1'b1)
      `CHK("bp_data",  out_data, 8'h81)
      `CHK("bp_count", out_count, 3'd2)
      `CHK("bp_ready", in_ready, 1'b0)
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    drain();
    `CHK("bp_rel_ready", in_ready, 1'b1)
    `CHK("bp_rel_valid", out_valid, 1'b0)

    beat(OP_OR, 8'h01, 1'b0);
    beat(OP_OR, 8'h02, 1'b0);
    rst = 1'b1;
    #2;
    chk_reset("mrst");
    `CHK("mrst_valid", out_valid, 1'b0)
    `CHK("mrst_data",  out_data, 8'h00)
    `CHK("mrst_count", out_count, 3'd0)
    `CHK("mrst_ovf",   out_ovf, 1'b0)
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    `CHK("mrst_novalid", out_valid, 1'b0)
    `CHK("mrst_ready",   in_ready, 1'b1)
    beat(OP_OR, 8'h81, 1'b1);
    wait_out_valid("mrst_next", 1);
    `CHK("mrst_next_data",  out_data, 8'h81)
    `CHK("mrst_next_count", out_count, 3'd1)
    drain();

`ifdef LOGIC_REDUCE_PARITY_EN
    beat(OP_AND, 8'h07, 1'b0);
    beat(OP_AND, 8'h0F, 1'b1);
    wait_out_valid("par", 1);
    `CHK("par_data", out_data, 8'h07)
    `CHK("par_bit",  out_parity, 1'b1)
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
